gcd_dispatch: RTL and testbench

GCD_DISPATCH -- requirements
Module: gcd_dispatch

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_pair_fifo.sv | 81 ++++++++
 rtl/gcd_dispatch.sv | 148 ++++++++++++++
 tb/tb_gcd_dispatch.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD dispatcher: FSM state encoding and default operand width.
package gcd_pkg;

    localparam int GCD_OP_SZ = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } gcd_state_e;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO for the GCD dispatcher; stores {a,b} pairs, supports simultaneous push and pop.
module gcd_pair_fifo #(
    parameter int OP_SZ = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [OP_SZ-1:0]         push_a_i,
    input  logic [OP_SZ-1:0]         push_b_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic [OP_SZ-1:0]         head_a_o,
    output logic [OP_SZ-1:0]         head_b_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [2*OP_SZ-1:0] mem_q [DEPTH];
    logic [2*OP_SZ-1:0] mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == {(AW + 1){1'b0}});
    assign count_o  = count_q;
    assign head_a_o = mem_q[rd_ptr_q][2*OP_SZ-1:OP_SZ];
    assign head_b_o = mem_q[rd_ptr_q][OP_SZ-1:0];

    // Next-state for storage, pointers and occupancy; a push while full is dropped.
    always_comb begin
        push_ok_s = push_i && !full_o;
        pop_ok_s  = pop_i && !empty_o;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = {push_a_i, push_b_i};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(2 * OP_SZ){1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gcd_dispatch.sv
// Dispatches queued operand pairs to an external GCD core one at a time and returns results in order.
// Optional macro GCD_DISPATCH_ZERO_BYPASS_EN: pairs with a zero operand skip the core.
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int OP_SZ = GCD_OP_SZ,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_SZ-1:0]         in_a,
    input  logic [OP_SZ-1:0]         in_b,
    output logic                     core_start,
    output logic [OP_SZ-1:0]         core_a,
    output logic [OP_SZ-1:0]         core_b,
    input  logic [OP_SZ-1:0]         core_res,
    input  logic                     core_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_SZ-1:0]         out_res,
    output logic [$clog2(DEPTH):0]   pending
);

    gcd_state_e       state_q, state_d;
    logic             core_start_q, core_start_d;
    logic [OP_SZ-1:0] core_a_q, core_a_d;
    logic [OP_SZ-1:0] core_b_q, core_b_d;
    logic             out_valid_q, out_valid_d;
    logic [OP_SZ-1:0] out_res_q, out_res_d;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [OP_SZ-1:0] head_a_s;
    logic [OP_SZ-1:0] head_b_s;

    gcd_pair_fifo #(
        .OP_SZ (OP_SZ),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (in_valid),
        .push_a_i (in_a),
        .push_b_i (in_b),
        .full_o   (fifo_full_s),
        .pop_i    (pop_s),
        .head_a_o (head_a_s),
        .head_b_o (head_b_s),
        .empty_o  (fifo_empty_s),
        .count_o  (pending)
    );

    assign in_ready   = !fifo_full_s;
    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign out_valid  = out_valid_q;
    assign out_res    = out_res_q;

    // Dispatcher FSM: all outputs are registered, so each transition sets the next-cycle values.
    always_comb begin
        state_d      = state_q;
        core_start_d = core_start_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        out_valid_d  = out_valid_q;
        out_res_d    = out_res_q;
        pop_s        = 1'b0;
        case (state_q)
            IDLE: begin
                core_start_d = 1'b0;
                out_valid_d  = 1'b0;
                if (!fifo_empty_s) begin
                    pop_s    = 1'b1;
                    core_a_d = head_a_s;
                    core_b_d = head_b_s;
`ifdef GCD_DISPATCH_ZERO_BYPASS_EN
                    if ((head_a_s == {OP_SZ{1'b0}}) || (head_b_s == {OP_SZ{1'b0}})) begin
                        out_res_d   = head_a_s | head_b_s;
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        core_start_d = 1'b1;
                        state_d      = RUN;
                    end
`else
                    core_start_d = 1'b1;
                    state_d      = RUN;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (core_done) begin
                    core_start_d = 1'b0;
                    state_d      = CAPTURE;
                end else begin
                    core_start_d = 1'b1;
                    state_d      = RUN;
                end
            end
            CAPTURE: begin
                core_start_d = 1'b0;
                out_res_d    = core_res;
                out_valid_d  = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                core_start_d = 1'b0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            default: begin
                core_start_d = 1'b0;
                out_valid_d  = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            core_start_q <= 1'b0;
            core_a_q     <= {OP_SZ{1'b0}};
            core_b_q     <= {OP_SZ{1'b0}};
            out_valid_q  <= 1'b0;
            out_res_q    <= {OP_SZ{1'b0}};
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            out_valid_q  <= out_valid_d;
            out_res_q    <= out_res_d;
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Scoreboard bench for gcd_dispatch with a behavioural GCD core stub and a Euclid reference model.
module tb_gcd_dispatch;

    localparam int OP_SZ = 8;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OP_SZ-1:0] in_a = 8'd0;
    logic [OP_SZ-1:0] in_b = 8'd0;
    logic             core_start;
    logic [OP_SZ-1:0] core_a;
    logic [OP_SZ-1:0] core_b;
    logic [OP_SZ-1:0] core_res = 8'd0;
    logic             core_done = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OP_SZ-1:0] out_res;
    logic [PW-1:0]    pending;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    bit stall = 1'b0;
    bit rand_rdy = 1'b0;
    bit rdy_fixed = 1'b1;
    int core_cnt = 0;
    int core_lat = 2;
    bit prev_start = 1'b0;
    bit prev_hold = 1'b0;
    bit exp_low = 1'b0;
    logic [OP_SZ-1:0] held_res = 8'd0;
    logic [15:0] mon_p;

    logic [OP_SZ-1:0] exp_q[$];
    logic [15:0]      pair_q[$];

    gcd_dispatch #(.OP_SZ(OP_SZ), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_res   (core_res),
        .core_done  (core_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .pending    (pending)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [OP_SZ-1:0] gcd_ref(input int unsigned a, input int unsigned b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return OP_SZ'(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready driver, changed away from both clock edges.
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // GCD core stub: answers after a random number of start cycles, holds the result afterwards.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            core_done = 1'b0;
            core_cnt  = 0;
        end else if (core_done) begin
            core_done = 1'b0;
        end else if (core_start && !stall) begin
            core_cnt++;
            if (core_cnt >= core_lat) begin
                core_done = 1'b1;
                core_res  = gcd_ref(core_a, core_b);
                core_cnt  = 0;
                core_lat  = $urandom_range(1, 4);
            end
        end
    end

    // Monitor: result scoreboard, hold/drop protocol, dispatch order and start/valid exclusion.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            prev_start = 1'b0;
            prev_hold  = 1'b0;
            exp_low    = 1'b0;
        end else begin
            if (exp_low) chk("valid_drop", 32'(out_valid), 32'd0);
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_res", 32'(out_res), 32'(held_res));
            end
            if (core_start || out_valid) chk("start_vs_valid", 32'(core_start && out_valid), 32'd0);
            if (core_start && !prev_start) begin
                starts++;
`ifdef GCD_DISPATCH_ZERO_BYPASS_EN
                while (pair_q.size() > 0 && (pair_q[0][15:8] == 8'd0 || pair_q[0][7:0] == 8'd0))
                    void'(pair_q.pop_front());
`endif
                if (pair_q.size() == 0) begin
                    chk("start_without_pair", 32'd0, 32'd1);
                end else begin
                    mon_p = pair_q.pop_front();
                    chk("core_a", 32'(core_a), 32'(mon_p[15:8]));
                    chk("core_b", 32'(core_b), 32'(mon_p[7:0]));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 32'd0, 32'd1);
                else chk("out_res", 32'(out_res), 32'(exp_q.pop_front()));
            end
            exp_low    = out_valid && out_ready;
            prev_hold  = out_valid && !out_ready;
            held_res   = out_res;
            prev_start = core_start;
        end
    end

    task automatic push_pair(input logic [OP_SZ-1:0] a, input logic [OP_SZ-1:0] b,
                             input int max_cyc, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < max_cyc; i++) begin
            if (in_ready) begin
                @(posedge clk);
                acc = 1'b1;
                exp_q.push_back(gcd_ref(a, b));
                pair_q.push_back({a, b});
                break;
            end
            @(negedge clk);
        end
        if (acc) begin
            #1;
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid && !core_start && pending == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_signal_high(input string name, input bit use_start);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (use_start ? core_start : out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        bit acc;
        int s0;
        logic [OP_SZ-1:0] ra, rb;

        // Reset state, both during and after reset.
        repeat (2) @(negedge clk);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_core_ab", 32'({core_a, core_b}), 32'd0);
        chk("rst_out_res", 32'(out_res), 32'd0);

        // (60,48): start latency, then result 12.
        push_pair(8'd60, 8'd48, 5, acc);
        chk("accept_60_48", 32'(acc), 32'd1);
        @(negedge clk);
        chk("lat_start_low", 32'(core_start), 32'd0);
        chk("lat_pending1", 32'(pending), 32'd1);
        @(negedge clk);
        chk("lat_start_high", 32'(core_start), 32'd1);
        chk("lat_pending0", 32'(pending), 32'd0);
        wait_drain("drain_60_48");

        // Back-to-back pairs come out in order.
        push_pair(8'd24, 8'd48, 5, acc);
        push_pair(8'd10, 8'd10, 5, acc);
        wait_drain("drain_b2b");

        // Result held under backpressure while the stalled queue fills up.
        rdy_fixed = 1'b0;
        push_pair(8'd60, 8'd48, 5, acc);
        wait_signal_high("wait_valid_12", 1'b0);
        stall = 1'b1;
        push_pair(8'd12, 8'd18, 5, acc);
        push_pair(8'd35, 8'd14, 5, acc);
        push_pair(8'd100, 8'd75, 5, acc);
        push_pair(8'd81, 8'd27, 5, acc);
        @(negedge clk);
        chk("full_pending", 32'(pending), 32'(DEPTH));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        push_pair(8'd5, 8'd10, 3, acc);
        chk("fifth_rejected", 32'(acc), 32'd0);
        chk("full_pending_kept", 32'(pending), 32'(DEPTH));
        repeat (3) begin
            @(negedge clk);
            chk("held_valid", 32'(out_valid), 32'd1);
            chk("held_res12", 32'(out_res), 32'd12);
            chk("no_start_while_held", 32'(core_start), 32'd0);
        end
        stall = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain("drain_full");

        // Reset during RUN discards everything.
        stall = 1'b1;
        push_pair(8'd60, 8'd48, 5, acc);
        push_pair(8'd7, 8'd7, 5, acc);
        wait_signal_high("wait_run", 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_start", 32'(core_start), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        pair_q.delete();
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        push_pair(8'd9, 8'd6, 5, acc);
        wait_drain("drain_9_6");

        // Zero operand: core bypassed only when the option is built in.
        s0 = starts;
        push_pair(8'd0, 8'd35, 5, acc);
        wait_drain("drain_0_35");
`ifdef GCD_DISPATCH_ZERO_BYPASS_EN
        chk("zero_core_starts", 32'(starts - s0), 32'd0);
`else
        chk("zero_core_starts", 32'(starts - s0), 32'd1);
`endif

        // Random traffic with random backpressure and core latency.
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 1) == 1) begin
                ra = 8'(ra * 3);
                rb = 8'(rb * 3);
            end
            push_pair(ra, rb, 80, acc);
            chk("rand_accept", 32'(acc), 32'd1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain("drain_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
